// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared state encoding and default width for the serial capture block
package shift_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/shift_chain_n.sv
// rtl/shift_chain_n.sv - WIDTH-bit resettable shift chain, d enters bit 0
module shift_chain_n #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (en) begin
            q <= {q[WIDTH-2:0], d};
        end
    end

endmodule

// File: rtl/shift_seq_ctrl.sv
// rtl/shift_seq_ctrl.sv - serial-to-parallel capture sequencer with valid/ready hold
module shift_seq_ctrl
    import shift_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       abort,
    input  logic                       din,
    input  logic                       out_ready,
    output logic                       busy,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(WIDTH+1)-1:0] bit_cnt
);

    localparam int CW = $clog2(WIDTH+1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt_nxt;
    logic          shift_en;

    shift_chain_n #(.WIDTH(WIDTH)) u_chain (
        .clk (clk),
        .rst (rst),
        .en  (shift_en),
        .d   (din),
        .q   (out_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
        end else begin
            state   <= state_nxt;
            bit_cnt <= cnt_nxt;
        end
    end

    // abort is checked before the shift so a coinciding final bit never reaches HOLD
    always_comb begin
        state_nxt = state;
        cnt_nxt   = bit_cnt;
        shift_en  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_SHIFT;
                    cnt_nxt   = '0;
                end
            end
            ST_SHIFT: begin
                if (abort) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    shift_en = 1'b1;
                    cnt_nxt  = bit_cnt + CW'(1);
                    if (bit_cnt == LAST_BIT) begin
                        state_nxt = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    cnt_nxt   = '0;
                    state_nxt = start ? ST_SHIFT : ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign busy      = (state == ST_SHIFT);
    assign out_valid = (state == ST_HOLD);

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// tb/tb_shift_seq_ctrl.sv - self-checking bench for shift_seq_ctrl (WIDTH=4)
module tb_shift_seq_ctrl;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic         din = 1'b0;
    logic         out_ready = 1'b0;
    logic         busy;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic [2:0]   bit_cnt;

    int checks = 0;
    int failures = 0;

    shift_seq_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .din       (din),
        .out_ready (out_ready),
        .busy      (busy),
        .out_valid (out_valid),
        .out_data  (out_data),
        .bit_cnt   (bit_cnt)
    );

    always #5 clk = ~clk;

    // reference: a word in progress, a word held, or neither; chain kept as an integer value
    bit m_busy;
    bit m_valid;
    int m_chain;
    int m_cnt;

    task automatic model_reset();
        m_busy  = 0;
        m_valid = 0;
        m_chain = 0;
        m_cnt   = 0;
    endtask

    task automatic model_edge(input bit s, input bit a, input bit d, input bit r);
        if (m_busy) begin
            if (a) begin
                m_busy = 0;
                m_cnt  = 0;
            end else begin
                m_chain = (m_chain * 2 + int'(d)) % (1 << W);
                m_cnt   = m_cnt + 1;
                if (m_cnt == W) begin
                    m_busy  = 0;
                    m_valid = 1;
                end
            end
        end else if (m_valid) begin
            if (r) begin
                m_valid = 0;
                m_cnt   = 0;
                m_busy  = s;
            end
        end else if (s) begin
            m_busy = 1;
            m_cnt  = 0;
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".busy"}, int'(busy), int'(m_busy));
        chk({tag, ".valid"}, int'(out_valid), int'(m_valid));
        chk({tag, ".data"}, int'(out_data), m_chain);
        chk({tag, ".cnt"}, int'(bit_cnt), m_cnt);
    endtask

    // inputs driven 1 time unit after an edge, outputs sampled 1 time unit after the next
    task automatic step(input bit s, input bit a, input bit d, input bit r);
        start = s; abort = a; din = d; out_ready = r;
        @(posedge clk);
        model_edge(s, a, d, r);
        #1;
    endtask

    typedef struct {
        logic       s, a, d, r;
        logic       e_busy, e_valid;
        logic [3:0] e_data;
        logic [2:0] e_cnt;
    } vec_t;

    vec_t tbl[22];

    function automatic vec_t mk(input logic s, a, d, r, eb, ev, input logic [3:0] ed, input logic [2:0] ec);
        vec_t v;
        v.s = s; v.a = a; v.d = d; v.r = r;
        v.e_busy = eb; v.e_valid = ev; v.e_data = ed; v.e_cnt = ec;
        return v;
    endfunction

    initial begin
        // basic word 1,0,1,1
        tbl[0]  = mk(1, 0, 0, 0, 1, 0, 4'b0000, 3'd0);
        tbl[1]  = mk(0, 0, 1, 0, 1, 0, 4'b0001, 3'd1);
        tbl[2]  = mk(0, 0, 0, 0, 1, 0, 4'b0010, 3'd2);
        tbl[3]  = mk(0, 0, 1, 0, 1, 0, 4'b0101, 3'd3);
        tbl[4]  = mk(0, 0, 1, 0, 0, 1, 4'b1011, 3'd4);
        // backpressure for 5 cycles, one with start that must be dropped
        tbl[5]  = mk(0, 0, 0, 0, 0, 1, 4'b1011, 3'd4);
        tbl[6]  = mk(0, 0, 1, 0, 0, 1, 4'b1011, 3'd4);
        tbl[7]  = mk(1, 0, 0, 0, 0, 1, 4'b1011, 3'd4);
        tbl[8]  = mk(0, 1, 1, 0, 0, 1, 4'b1011, 3'd4);
        tbl[9]  = mk(0, 0, 0, 0, 0, 1, 4'b1011, 3'd4);
        tbl[10] = mk(0, 0, 0, 1, 0, 0, 4'b1011, 3'd0);
        // second 1,0,1,1 with start held high during shift
        tbl[11] = mk(1, 0, 0, 0, 1, 0, 4'b1011, 3'd0);
        tbl[12] = mk(1, 0, 1, 0, 1, 0, 4'b0111, 3'd1);
        tbl[13] = mk(1, 0, 0, 0, 1, 0, 4'b1110, 3'd2);
        tbl[14] = mk(1, 0, 1, 0, 1, 0, 4'b1101, 3'd3);
        tbl[15] = mk(0, 0, 1, 0, 0, 1, 4'b1011, 3'd4);
        // handshake with start -> straight into 0,1,1,0
        tbl[16] = mk(1, 0, 0, 1, 1, 0, 4'b1011, 3'd0);
        tbl[17] = mk(1, 0, 0, 1, 1, 0, 4'b0110, 3'd1);
        tbl[18] = mk(1, 0, 1, 1, 1, 0, 4'b1101, 3'd2);
        tbl[19] = mk(1, 0, 1, 1, 1, 0, 4'b1011, 3'd3);
        tbl[20] = mk(0, 0, 0, 0, 0, 1, 4'b0110, 3'd4);
        tbl[21] = mk(0, 0, 0, 1, 0, 0, 4'b0110, 3'd0);

        model_reset();
        #2;
        chk("reset.busy", int'(busy), 0);
        chk("reset.valid", int'(out_valid), 0);
        chk("reset.data", int'(out_data), 0);
        chk("reset.cnt", int'(bit_cnt), 0);
        @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 22; i++) begin
            step(tbl[i].s, tbl[i].a, tbl[i].d, tbl[i].r);
            chk($sformatf("vec%0d.busy", i), int'(busy), int'(tbl[i].e_busy));
            chk($sformatf("vec%0d.valid", i), int'(out_valid), int'(tbl[i].e_valid));
            chk($sformatf("vec%0d.data", i), int'(out_data), int'(tbl[i].e_data));
            chk($sformatf("vec%0d.cnt", i), int'(bit_cnt), int'(tbl[i].e_cnt));
        end

        // abort after two bits: chain keeps its partial contents
        step(1, 0, 0, 0);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        step(0, 1, 0, 0);
        chk("abort2.busy", int'(busy), 0);
        chk("abort2.cnt", int'(bit_cnt), 0);
        chk("abort2.data", int'(out_data), 4'b1011);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1, 1);
            chk("abort2.novalid", int'(out_valid), 0);
        end

        // abort coincides with the fourth bit
        step(1, 0, 0, 0);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        step(0, 1, 1, 0);
        chk("abort4.valid", int'(out_valid), 0);
        chk("abort4.busy", int'(busy), 0);
        chk("abort4.cnt", int'(bit_cnt), 0);
        chk_model("abort4");

        // asynchronous reset between edges with bit_cnt=2
        step(1, 0, 0, 0);
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        chk("arst.pre_cnt", int'(bit_cnt), 2);
        #2 rst = 1'b1;
        #1;
        chk("arst.busy", int'(busy), 0);
        chk("arst.valid", int'(out_valid), 0);
        chk("arst.data", int'(out_data), 0);
        chk("arst.cnt", int'(bit_cnt), 0);
        rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        chk("arst.word", int'(out_data), 4'b0110);
        chk("arst.wvalid", int'(out_valid), 1);

        // start held high through HOLD without ready: no restart
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 0, 0);
            chk("holdstart.valid", int'(out_valid), 1);
            chk("holdstart.busy", int'(busy), 0);
        end
        step(0, 0, 0, 1);
        chk_model("holdstart.release");

        // randomized run against the reference
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(2) == 0), ($urandom_range(9) == 0),
                 1'($urandom_range(1)), ($urandom_range(1) == 1));
            chk_model($sformatf("rnd%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
